// File: rtl/pwmdecode_pkg.sv
// Shared constants for the PWM receive decoder: FSM encoding, default timing and duty saturation.
package pwmdecode_pkg;

  localparam logic [1:0] ST_WAITRISE = 2'd0;
  localparam logic [1:0] ST_HIGH     = 2'd1;
  localparam logic [1:0] ST_LOW      = 2'd2;

  localparam int unsigned DEF_NOMPERIOD = 32'd256;
  localparam int unsigned DEF_PERTOL    = 32'd4;
  localparam int unsigned DEF_TIMEOUT   = 32'd512;

  localparam logic [7:0] DUTY_SAT = 8'hff;

  function automatic logic [7:0] sat8(input logic [31:0] value);
    if (value > 32'd255) begin
      return DUTY_SAT;
    end else begin
      return value[7:0];
    end
  endfunction

endpackage

// File: rtl/pwmdecode8_pwmin_cond.sv
// PWM input conditioning: 2-FF synchroniser, polarity XOR, optional glitch filter, tick-qualified edges.
// Optional feature macro: GLITCH_FILTER_EN (3-sample majority-free level acceptance).
module pwmin_cond (
  input  logic clk,
  input  logic rstn,
  input  logic sampce,
  input  logic pwmin,
  input  logic invertin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic sync1_r;
  logic sync2_r;
  logic lvl_s;

  // two-stage synchroniser for the asynchronous input
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= pwmin;
      sync2_r <= sync1_r;
    end
  end

  assign lvl_s = sync2_r ^ invertin;

`ifdef GLITCH_FILTER_EN
  logic [1:0] hist_r;
  logic       filt_r;
  logic       accept_s;

  // a new level is accepted once it has been seen on three consecutive ticks
  always_comb begin
    accept_s = 1'b0;
    if ((lvl_s == hist_r[0]) && (lvl_s == hist_r[1]) && (lvl_s != filt_r)) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
  end

  // sample history and filtered level
  always_ff @(posedge clk) begin
    if (!rstn) begin
      hist_r <= 2'b00;
      filt_r <= 1'b0;
    end else if (sampce) begin
      hist_r <= {hist_r[0], lvl_s};
      if (accept_s) begin
        filt_r <= lvl_s;
      end
    end
  end

  assign level = filt_r;
  assign rise  = sampce & accept_s & lvl_s;
  assign fall  = sampce & accept_s & ~lvl_s;
`else
  logic prev_r;

  // level seen on the previous tick, for edge detection
  always_ff @(posedge clk) begin
    if (!rstn) begin
      prev_r <= 1'b0;
    end else if (sampce) begin
      prev_r <= lvl_s;
    end
  end

  assign level = lvl_s;
  assign rise  = sampce & lvl_s & ~prev_r;
  assign fall  = sampce & ~lvl_s & prev_r;
`endif

endmodule

// File: rtl/pwmdecode8.sv
// PWM receive decoder: measures period and high time in sampce ticks and publishes duty/period/status.
// Optional feature macro: GLITCH_FILTER_EN (input glitch filter inside pwmin_cond).
module pwmdecode8
  import pwmdecode_pkg::*;
#(
  parameter int CNTW      = 10,
  parameter int NOMPERIOD = DEF_NOMPERIOD,
  parameter int PERTOL    = DEF_PERTOL,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            sampce,
  input  logic            pwmin,
  input  logic            invertin,
  output logic [7:0]      dutyval,
  output logic [CNTW-1:0] periodval,
  output logic            dutyvalid,
  output logic            dclevel,
  output logic            perioderr
);

  localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);
  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};
  localparam logic [CNTW-1:0] PER_HI  = CNTW'(NOMPERIOD + PERTOL);
  localparam logic [CNTW-1:0] PER_LO  = CNTW'(NOMPERIOD - PERTOL);
  localparam logic [CNTW-1:0] TMO     = CNTW'(TIMEOUT);

  logic            level_s;
  logic            rise_s;
  logic            fall_s;
  logic [1:0]      state_r;
  logic [1:0]      state_n;
  logic [CNTW-1:0] percnt_r;
  logic [CNTW-1:0] percnt_n;
  logic [CNTW-1:0] percnt_inc_s;
  logic [CNTW-1:0] hicnt_r;
  logic [CNTW-1:0] hicnt_n;
  logic [CNTW-1:0] hilatch_r;
  logic [CNTW-1:0] hilatch_n;
  logic            pub_s;
  logic            tmo_s;

  pwmin_cond u_cond (
    .clk      (clk),
    .rstn     (rstn),
    .sampce   (sampce),
    .pwmin    (pwmin),
    .invertin (invertin),
    .level    (level_s),
    .rise     (rise_s),
    .fall     (fall_s)
  );

  assign percnt_inc_s = percnt_r + CNT_ONE;

  // measurement FSM; a rising edge always beats a coincident timeout
  always_comb begin
    state_n   = state_r;
    percnt_n  = percnt_r;
    hicnt_n   = hicnt_r;
    hilatch_n = hilatch_r;
    pub_s     = 1'b0;
    tmo_s     = 1'b0;
    if (sampce) begin
      case (state_r)
        ST_WAITRISE: begin
          if (rise_s) begin
            state_n  = ST_HIGH;
            percnt_n = CNT_ONE;
            hicnt_n  = CNT_ONE;
          end else begin
            percnt_n = percnt_inc_s;
          end
        end
        ST_HIGH: begin
          percnt_n = percnt_inc_s;
          if (fall_s) begin
            state_n   = ST_LOW;
            hilatch_n = hicnt_r;
          end else if (hicnt_r != CNT_MAX) begin
            hicnt_n = hicnt_r + CNT_ONE;
          end else begin
            hicnt_n = hicnt_r;
          end
        end
        ST_LOW: begin
          if (rise_s) begin
            pub_s    = 1'b1;
            state_n  = ST_HIGH;
            percnt_n = CNT_ONE;
            hicnt_n  = CNT_ONE;
          end else begin
            percnt_n = percnt_inc_s;
          end
        end
        default: begin
          state_n  = ST_WAITRISE;
          percnt_n = {CNTW{1'b0}};
          hicnt_n  = {CNTW{1'b0}};
        end
      endcase
      if (!rise_s && (percnt_inc_s == TMO)) begin
        tmo_s    = 1'b1;
        state_n  = ST_WAITRISE;
        percnt_n = {CNTW{1'b0}};
      end else begin
        tmo_s = 1'b0;
      end
    end else begin
      state_n = state_r;
    end
  end

  // FSM and counter registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r   <= ST_WAITRISE;
      percnt_r  <= {CNTW{1'b0}};
      hicnt_r   <= {CNTW{1'b0}};
      hilatch_r <= {CNTW{1'b0}};
    end else begin
      state_r   <= state_n;
      percnt_r  <= percnt_n;
      hicnt_r   <= hicnt_n;
      hilatch_r <= hilatch_n;
    end
  end

  // published results; held between strobes
  always_ff @(posedge clk) begin
    if (!rstn) begin
      dutyval   <= 8'h00;
      periodval <= {CNTW{1'b0}};
      dutyvalid <= 1'b0;
      dclevel   <= 1'b0;
      perioderr <= 1'b0;
    end else begin
      dutyvalid <= pub_s | tmo_s;
      if (pub_s) begin
        dutyval   <= sat8(32'(hilatch_r));
        periodval <= percnt_r;
        dclevel   <= 1'b0;
        perioderr <= (percnt_r > PER_HI) || (percnt_r < PER_LO);
      end else if (tmo_s) begin
        dutyval   <= level_s ? DUTY_SAT : 8'h00;
        periodval <= TMO;
        dclevel   <= 1'b1;
        perioderr <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pwmdecode8.sv
// Directed self-checking bench for pwmdecode8; honours GLITCH_FILTER_EN for the glitch scenario.
module tb_pwmdecode8;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       sampce = 1'b1;
  logic       pwmin = 1'b0;
  logic       invertin = 1'b0;
  logic [7:0] dutyval;
  logic [9:0] periodval;
  logic       dutyvalid;
  logic       dclevel;
  logic       perioderr;

  int checks = 0;
  int errors = 0;
  int strobes = 0;
  int cyc = 0;
  int cap_cyc = 0;
  int prev_cap_cyc = 0;
  logic [7:0] cap_duty = 8'h00;
  logic [9:0] cap_per = 10'd0;
  logic cap_dcl = 1'b0;
  logic cap_perr = 1'b0;
  bit prev_dv = 1'b0;
  bit dv_wide = 1'b0;
  bit half_rate = 1'b0;

  pwmdecode8 dut (
    .clk       (clk),
    .rstn      (rstn),
    .sampce    (sampce),
    .pwmin     (pwmin),
    .invertin  (invertin),
    .dutyval   (dutyval),
    .periodval (periodval),
    .dutyvalid (dutyvalid),
    .dclevel   (dclevel),
    .perioderr (perioderr)
  );

  always #5 clk = ~clk;

  // advance one clk; inputs change and outputs are sampled at the falling edge
  task automatic step();
    sampce = half_rate ? ((cyc % 2) == 0) : 1'b1;
    @(negedge clk);
    cyc++;
    if (dutyvalid) begin
      strobes++;
      prev_cap_cyc = cap_cyc;
      cap_cyc  = cyc;
      cap_duty = dutyval;
      cap_per  = periodval;
      cap_dcl  = dclevel;
      cap_perr = perioderr;
    end
    if (dutyvalid && prev_dv) dv_wide = 1'b1;
    prev_dv = dutyvalid;
  endtask

  task automatic drive(input logic lvl, input int n);
    pwmin = lvl;
    repeat (n) step();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    step();
    step();
    rstn = 1'b1;
  endtask

  task automatic wait_strobe(input int budget, output bit got);
    int s0;
    int n;
    s0 = strobes;
    n = 0;
    while (strobes == s0 && n < budget) begin
      step();
      n++;
    end
    got = (strobes != s0);
  endtask

  task automatic test_reset();
    invertin = 1'b0;
    pwmin = 1'b0;
    do_reset();
    checks++; if (dutyval !== 8'd0) begin errors++; $display("FAIL reset_duty: got %0d want 0", dutyval); end
    checks++; if (periodval !== 10'd0) begin errors++; $display("FAIL reset_period: got %0d want 0", periodval); end
    checks++; if (dutyvalid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", dutyvalid); end
    checks++; if (dclevel !== 1'b0) begin errors++; $display("FAIL reset_dclevel: got %0b want 0", dclevel); end
    checks++; if (perioderr !== 1'b0) begin errors++; $display("FAIL reset_perioderr: got %0b want 0", perioderr); end
  endtask

  task automatic test_basic();
    int s0;
    do_reset();
    drive(1'b0, 5);
    s0 = strobes;
    dv_wide = 1'b0;
    drive(1'b1, 100); drive(1'b0, 156); drive(1'b1, 100); drive(1'b0, 156); drive(1'b1, 10);
    checks++; if (strobes - s0 !== 2) begin errors++; $display("FAIL basic_count: got %0d want 2", strobes - s0); end
    checks++; if (cap_duty !== 8'd100) begin errors++; $display("FAIL basic_duty: got %0d want 100", cap_duty); end
    checks++; if (cap_per !== 10'd256) begin errors++; $display("FAIL basic_period: got %0d want 256", cap_per); end
    checks++; if (cap_perr !== 1'b0) begin errors++; $display("FAIL basic_perioderr: got %0b want 0", cap_perr); end
    checks++; if (cap_dcl !== 1'b0) begin errors++; $display("FAIL basic_dclevel: got %0b want 0", cap_dcl); end
    checks++; if (cap_cyc - prev_cap_cyc !== 256) begin errors++; $display("FAIL basic_spacing: got %0d want 256", cap_cyc - prev_cap_cyc); end
    checks++; if (dv_wide !== 1'b0) begin errors++; $display("FAIL basic_strobe_width: got wide=%0b want 0", dv_wide); end
    checks++; if (dutyvalid !== 1'b0) begin errors++; $display("FAIL basic_valid_low: got %0b want 0", dutyvalid); end
    checks++; if (dutyval !== 8'd100) begin errors++; $display("FAIL basic_hold: got %0d want 100", dutyval); end
  endtask

  task automatic test_saturate();
    int s0;
    do_reset();
    drive(1'b0, 5);
    s0 = strobes;
    drive(1'b1, 300); drive(1'b0, 10); drive(1'b1, 300); drive(1'b0, 10); drive(1'b1, 5);
    checks++; if (strobes - s0 !== 2) begin errors++; $display("FAIL sat_count: got %0d want 2", strobes - s0); end
    checks++; if (cap_duty !== 8'd255) begin errors++; $display("FAIL sat_duty: got %0d want 255", cap_duty); end
    checks++; if (cap_per !== 10'd310) begin errors++; $display("FAIL sat_period: got %0d want 310", cap_per); end
    checks++; if (cap_perr !== 1'b1) begin errors++; $display("FAIL sat_perioderr: got %0b want 1", cap_perr); end
  endtask

  task automatic test_timeout();
    bit got;
    int t0;
    do_reset();
    drive(1'b0, 5); drive(1'b1, 100); drive(1'b0, 156);
    pwmin = 1'b1;
    wait_strobe(20, got);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL tmo_first_strobe: got none want strobe"); end
    checks++; if (cap_duty !== 8'd100 || cap_dcl !== 1'b0) begin errors++; $display("FAIL tmo_first_values: got duty=%0d dc=%0b want 100/0", cap_duty, cap_dcl); end
    t0 = cap_cyc;
    wait_strobe(600, got);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL tmo_high_strobe: got none want strobe"); end
    checks++; if (cap_cyc - t0 !== 511) begin errors++; $display("FAIL tmo_high_delay: got %0d want 511", cap_cyc - t0); end
    checks++; if (cap_dcl !== 1'b1) begin errors++; $display("FAIL tmo_high_dclevel: got %0b want 1", cap_dcl); end
    checks++; if (cap_duty !== 8'd255) begin errors++; $display("FAIL tmo_high_duty: got %0d want 255", cap_duty); end
    checks++; if (cap_perr !== 1'b1) begin errors++; $display("FAIL tmo_high_perioderr: got %0b want 1", cap_perr); end
    checks++; if (cap_per !== 10'd512) begin errors++; $display("FAIL tmo_high_period: got %0d want 512", cap_per); end
    t0 = cap_cyc;
    pwmin = 1'b0;
    wait_strobe(600, got);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL tmo_low_strobe: got none want strobe"); end
    checks++; if (cap_cyc - t0 !== 512) begin errors++; $display("FAIL tmo_repeat_delay: got %0d want 512", cap_cyc - t0); end
    checks++; if (cap_duty !== 8'd0 || cap_dcl !== 1'b1) begin errors++; $display("FAIL tmo_low_values: got duty=%0d dc=%0b want 0/1", cap_duty, cap_dcl); end
  endtask

  task automatic test_invert();
    invertin = 1'b1;
    pwmin = 1'b1;
    do_reset();
    drive(1'b1, 8); drive(1'b0, 60); drive(1'b1, 196); drive(1'b0, 60); drive(1'b1, 196); drive(1'b0, 5);
    checks++; if (cap_duty !== 8'd60) begin errors++; $display("FAIL inv_duty: got %0d want 60", cap_duty); end
    checks++; if (cap_per !== 10'd256) begin errors++; $display("FAIL inv_period: got %0d want 256", cap_per); end
    checks++; if (cap_perr !== 1'b0) begin errors++; $display("FAIL inv_perioderr: got %0b want 0", cap_perr); end
    invertin = 1'b0;
    pwmin = 1'b0;
  endtask

  task automatic test_reset_mid();
    int s0;
    do_reset();
    drive(1'b0, 5); drive(1'b1, 100); drive(1'b0, 156); drive(1'b1, 50);
    checks++; if (dutyval !== 8'd100) begin errors++; $display("FAIL mid_pre_duty: got %0d want 100", dutyval); end
    rstn = 1'b0;
    step();
    checks++; if (dutyval !== 8'd0 || periodval !== 10'd0) begin errors++; $display("FAIL mid_reset_values: got duty=%0d per=%0d want 0/0", dutyval, periodval); end
    checks++; if (dutyvalid !== 1'b0 || dclevel !== 1'b0 || perioderr !== 1'b0) begin errors++; $display("FAIL mid_reset_flags: got v=%0b dc=%0b pe=%0b want 0", dutyvalid, dclevel, perioderr); end
    rstn = 1'b1;
    s0 = strobes;
    drive(1'b1, 49); drive(1'b0, 156);
    checks++; if (strobes - s0 !== 0) begin errors++; $display("FAIL mid_arm_only: got %0d strobes want 0", strobes - s0); end
    drive(1'b1, 10);
    checks++; if (strobes - s0 !== 1) begin errors++; $display("FAIL mid_first_strobe: got %0d want 1", strobes - s0); end
    checks++; if (cap_duty !== 8'd49 || cap_per !== 10'd205) begin errors++; $display("FAIL mid_values: got duty=%0d per=%0d want 49/205", cap_duty, cap_per); end
    checks++; if (cap_perr !== 1'b1) begin errors++; $display("FAIL mid_perioderr: got %0b want 1", cap_perr); end
  endtask

  task automatic test_glitch();
    int s0;
    do_reset();
    drive(1'b0, 5); drive(1'b1, 100); drive(1'b0, 156);
    s0 = strobes;
    drive(1'b1, 100); drive(1'b0, 60); drive(1'b1, 1); drive(1'b0, 10);
`ifdef GLITCH_FILTER_EN
    checks++; if (strobes - s0 !== 1) begin errors++; $display("FAIL glitch_count: got %0d want 1", strobes - s0); end
    checks++; if (cap_duty !== 8'd100 || cap_per !== 10'd256 || cap_perr !== 1'b0) begin errors++; $display("FAIL glitch_values: got %0d/%0d/%0b want 100/256/0", cap_duty, cap_per, cap_perr); end
`else
    checks++; if (strobes - s0 !== 2) begin errors++; $display("FAIL glitch_count: got %0d want 2", strobes - s0); end
    checks++; if (cap_duty !== 8'd100 || cap_per !== 10'd160 || cap_perr !== 1'b1) begin errors++; $display("FAIL glitch_values: got %0d/%0d/%0b want 100/160/1", cap_duty, cap_per, cap_perr); end
`endif
    drive(1'b0, 85); drive(1'b1, 5);
`ifdef GLITCH_FILTER_EN
    checks++; if (strobes - s0 !== 2) begin errors++; $display("FAIL glitch_next_count: got %0d want 2", strobes - s0); end
    checks++; if (cap_duty !== 8'd100 || cap_per !== 10'd256) begin errors++; $display("FAIL glitch_next_values: got %0d/%0d want 100/256", cap_duty, cap_per); end
`else
    checks++; if (strobes - s0 !== 3) begin errors++; $display("FAIL glitch_next_count: got %0d want 3", strobes - s0); end
    checks++; if (cap_duty !== 8'd1 || cap_per !== 10'd96) begin errors++; $display("FAIL glitch_next_values: got %0d/%0d want 1/96", cap_duty, cap_per); end
`endif
  endtask

  task automatic test_half_rate();
    int s0;
    half_rate = 1'b1;
    do_reset();
    drive(1'b0, 6);
    s0 = strobes;
    dv_wide = 1'b0;
    drive(1'b1, 200); drive(1'b0, 312); drive(1'b1, 200); drive(1'b0, 312); drive(1'b1, 8);
    half_rate = 1'b0;
    checks++; if (strobes - s0 !== 2) begin errors++; $display("FAIL half_count: got %0d want 2", strobes - s0); end
    checks++; if (cap_duty !== 8'd100 || cap_per !== 10'd256) begin errors++; $display("FAIL half_values: got %0d/%0d want 100/256", cap_duty, cap_per); end
    checks++; if (dv_wide !== 1'b0) begin errors++; $display("FAIL half_strobe_width: got wide=%0b want 0", dv_wide); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_timeout();
    test_invert();
    test_reset_mid();
    test_glitch();
    test_half_rate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
